// File: rtl/sram_cmp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sram_cmp_pkg                                              |
// | Purpose  : Shared types and default sizes for the SRAM compare       |
// |            sequencer and its compare stage.                          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package sram_cmp_pkg;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_word_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sram_word_cmp                                             |
// | Purpose  : Registered word inequality with valid/offset sideband and |
// |            a synchronous flush that drops the word being captured.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sram_word_cmp #(
  parameter int DW = 32,
  parameter int OW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_vld,
  input  logic [OW-1:0] in_off,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          out_vld,
  output logic          out_mis,
  output logic [OW-1:0] out_off
);

  // Capture one compare result per valid word; a flush kills the word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_mis <= 1'b0;
      out_off <= '0;
    end else begin
      out_vld <= in_vld && !flush;
      if (in_vld) begin
        out_mis <= (a != b);
        out_off <= in_off;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_cmp_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sram_cmp_seq_ctrl                                         |
// | Purpose  : Sweeps two SRAM regions word by word, compares paired     |
// |            reads, counts mismatches and reports the first offset.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sram_cmp_seq_ctrl
  import sram_cmp_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int LEN_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             stop_first_i,
  input  logic [AW-1:0]    base_a_i,
  input  logic [AW-1:0]    base_b_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             sram_a_ce_o,
  output logic [AW-1:0]    sram_a_addr_o,
  input  logic [DW-1:0]    sram_a_rdata_i,
  output logic             sram_b_ce_o,
  output logic [AW-1:0]    sram_b_addr_o,
  input  logic [DW-1:0]    sram_b_rdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             mismatch_o,
  output logic [LEN_W-1:0] first_off_o,
  output logic [LEN_W-1:0] mismatch_cnt_o
);

  state_t             state, state_nxt;
  logic [AW-1:0]      base_a_q, base_b_q;
  logic [LEN_W-1:0]   len_q;
  logic               stop_q;
  logic [LEN_W-1:0]   off;
  logic               s1_vld;
  logic [LEN_W-1:0]   s1_off;
  logic               cmp_vld, cmp_mis;
  logic [LEN_W-1:0]   cmp_off;
  logic               start_ok, stop_hit, issue, last_issue, flush, active;

  // Sweep control decodes shared by the FSM and the datapath.
  always_comb begin
    active     = (state == ST_RUN) || (state == ST_DRAIN);
    start_ok   = (state == ST_IDLE) && start_i && !abort_i;
    // In stop-first mode the first mismatch result halts issue in the same cycle.
    stop_hit   = stop_q && cmp_vld && cmp_mis && active;
    issue      = (state == ST_RUN) && !abort_i && !stop_hit;
    last_issue = issue && (off == (len_q - LEN_W'(1)));
    flush      = abort_i || stop_hit;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt   = state;
    sram_a_ce_o = issue;
    sram_b_ce_o = issue;
    busy_o      = (state != ST_IDLE);
    done_o      = (state == ST_DONE) && !abort_i;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = (len_i == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (stop_hit || last_issue) state_nxt = ST_DRAIN;
      // Only the compare stage may still hold a result once the read stage is empty.
      ST_DRAIN: if (!s1_vld) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort_i && (state != ST_IDLE)) state_nxt = ST_IDLE;
  end

  // Latch the sweep request and step the offset counter on each issued pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_a_q <= '0;
      base_b_q <= '0;
      len_q    <= '0;
      stop_q   <= 1'b0;
      off      <= '0;
    end else if (start_ok) begin
      base_a_q <= base_a_i;
      base_b_q <= base_b_i;
      len_q    <= len_i;
      stop_q   <= stop_first_i;
      off      <= '0;
    end else if (issue) begin
      off      <= off + LEN_W'(1);
    end
  end

  // Addresses wrap naturally modulo 2^AW.
  assign sram_a_addr_o = base_a_q + off[AW-1:0];
  assign sram_b_addr_o = base_b_q + off[AW-1:0];

  // Read-data stage: tags the word arriving from the SRAMs with its offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_off <= '0;
    end else begin
      s1_vld <= issue;
      if (issue) s1_off <= off;
    end
  end

  sram_word_cmp #(
    .DW (DW),
    .OW (LEN_W)
  ) u_cmp (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .in_vld  (s1_vld),
    .in_off  (s1_off),
    .a       (sram_a_rdata_i),
    .b       (sram_b_rdata_i),
    .out_vld (cmp_vld),
    .out_mis (cmp_mis),
    .out_off (cmp_off)
  );

  // Status accumulation; cleared on an accepted start, frozen on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_o     <= 1'b0;
      first_off_o    <= '0;
      mismatch_cnt_o <= '0;
    end else if (start_ok) begin
      mismatch_o     <= 1'b0;
      first_off_o    <= '0;
      mismatch_cnt_o <= '0;
    end else if (cmp_vld && cmp_mis && active && !abort_i) begin
      if (mismatch_cnt_o != '1) mismatch_cnt_o <= mismatch_cnt_o + LEN_W'(1);
      if (!mismatch_o) begin
        mismatch_o  <= 1'b1;
        first_off_o <= cmp_off;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_cmp_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_sram_cmp_seq_ctrl                                      |
// | Purpose  : Self-checking bench for the SRAM compare sequencer.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_sram_cmp_seq_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int LEN_W = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0, abort_i = 1'b0, stop_first_i = 1'b0;
  logic [AW-1:0]    base_a_i = '0, base_b_i = '0;
  logic [LEN_W-1:0] len_i = '0;
  logic             sram_a_ce_o, sram_b_ce_o;
  logic [AW-1:0]    sram_a_addr_o, sram_b_addr_o;
  logic [DW-1:0]    sram_a_rdata_i = '0, sram_b_rdata_i = '0;
  logic             busy_o, done_o, mismatch_o;
  logic [LEN_W-1:0] first_off_o, mismatch_cnt_o;

  sram_cmp_seq_ctrl #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .stop_first_i(stop_first_i), .base_a_i(base_a_i), .base_b_i(base_b_i),
    .len_i(len_i), .sram_a_ce_o(sram_a_ce_o), .sram_a_addr_o(sram_a_addr_o),
    .sram_a_rdata_i(sram_a_rdata_i), .sram_b_ce_o(sram_b_ce_o),
    .sram_b_addr_o(sram_b_addr_o), .sram_b_rdata_i(sram_b_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .mismatch_o(mismatch_o),
    .first_off_o(first_off_o), .mismatch_cnt_o(mismatch_cnt_o)
  );

  always #5 clk = ~clk;

  // Single-port SRAM read models, one cycle of read latency.
  logic [DW-1:0] mem_a [0:DEPTH-1];
  logic [DW-1:0] mem_b [0:DEPTH-1];
  always @(posedge clk) begin
    if (sram_a_ce_o) sram_a_rdata_i <= mem_a[sram_a_addr_o];
    if (sram_b_ce_o) sram_b_rdata_i <= mem_b[sram_b_addr_o];
  end

  typedef struct {
    logic [AW-1:0] base_a;
    logic [AW-1:0] base_b;
    int            len;
    bit            stop;
    int            mis0;   // -1 = none
    int            mis1;   // -1 = none
  } vec_t;

  typedef struct {
    int lat;
    int ce_n;
    int mis;
    int cnt;
    int first;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model of one sweep's outcome.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    int   n     = 0;
    int   first = v.len;
    if (v.mis0 >= 0 && v.mis0 < v.len) begin n++; if (v.mis0 < first) first = v.mis0; end
    if (v.mis1 >= 0 && v.mis1 < v.len && v.mis1 != v.mis0) begin
      n++; if (v.mis1 < first) first = v.mis1;
    end
    if (v.len == 0) begin
      e.lat = 1; e.ce_n = 0;
    end else if (v.stop && n > 0) begin
      e.lat  = (first + 5 < v.len + 3) ? first + 5 : v.len + 3;
      e.ce_n = (first + 2 < v.len) ? first + 2 : v.len;
      n = 1;
    end else begin
      e.lat = v.len + 3; e.ce_n = v.len;
    end
    e.mis   = (n > 0) ? 1 : 0;
    e.cnt   = n;
    e.first = (n > 0) ? first : 0;
    return e;
  endfunction

  task automatic load(input vec_t v);
    logic [AW-1:0] ia, ib;
    logic [DW-1:0] d;
    for (int i = 0; i < v.len; i++) begin
      ia = v.base_a + AW'(i);
      ib = v.base_b + AW'(i);
      d  = $urandom;
      mem_a[ia] = d;
      mem_b[ib] = (i == v.mis0 || i == v.mis1) ? (d ^ 32'h0000_0100) : d;
    end
  endtask

  task automatic drive_start(input vec_t v);
    base_a_i     = v.base_a;
    base_b_i     = v.base_b;
    len_i        = LEN_W'(v.len);
    stop_first_i = v.stop;
    start_i      = 1'b1;
  endtask

  // Apply one sweep; restart_at > 0 pulses a stray start in that cycle.
  task automatic run(input vec_t v, input int restart_at);
    exp_t          e;
    int            lat = 0, issued = 0;
    bit            addr_ok = 1'b1, done_seen = 1'b0;
    logic [AW-1:0] ea, eb;
    load(v);
    @(negedge clk);
    drive_start(v);
    sb.push_back(model(v));
    while (!done_seen && lat < v.len + 40) begin
      @(negedge clk);
      lat++;
      start_i = 1'b0;
      if (sram_a_ce_o || sram_b_ce_o) begin
        ea = v.base_a + AW'(issued);
        eb = v.base_b + AW'(issued);
        if (!(sram_a_ce_o && sram_b_ce_o) || sram_a_addr_o != ea || sram_b_addr_o != eb)
          addr_ok = 1'b0;
        issued++;
      end
      if (done_o) done_seen = 1'b1;
      if (lat == restart_at) begin
        base_a_i = 10'h155; base_b_i = 10'h2AA; len_i = LEN_W'(3); start_i = 1'b1;
      end
    end
    e = sb.pop_front();
    check("done_seen",  done_seen,      1);
    check("latency",    lat,            e.lat);
    check("ce_cycles",  issued,         e.ce_n);
    check("addr_seq",   addr_ok,        1);
    check("mismatch",   mismatch_o,     e.mis);
    check("count",      mismatch_cnt_o, e.cnt);
    check("first_off",  first_off_o,    e.first);
    @(negedge clk);
    check("busy_after", busy_o, 0);
    check("done_pulse", done_o, 0);
  endtask

  vec_t vecs[7];
  vec_t v;

  initial begin
    vecs[0] = '{base_a: 10'h000, base_b: 10'h100, len: 16,   stop: 1'b0, mis0: -1, mis1: -1};
    vecs[1] = '{base_a: 10'h000, base_b: 10'h100, len: 16,   stop: 1'b0, mis0: 3,  mis1: 9};
    vecs[2] = '{base_a: 10'h000, base_b: 10'h100, len: 16,   stop: 1'b1, mis0: 3,  mis1: 9};
    vecs[3] = '{base_a: 10'h020, base_b: 10'h040, len: 0,    stop: 1'b0, mis0: -1, mis1: -1};
    vecs[4] = '{base_a: 10'h3FE, base_b: 10'h010, len: 1024, stop: 1'b0, mis0: 1,  mis1: 2};
    vecs[5] = '{base_a: 10'h3FD, base_b: 10'h200, len: 5,    stop: 1'b1, mis0: 4,  mis1: -1};
    vecs[6] = '{base_a: 10'h080, base_b: 10'h300, len: 16,   stop: 1'b1, mis0: 0,  mis1: 7};

    // Reset state.
    #12;
    check("rst_ce",    {sram_a_ce_o, sram_b_ce_o}, 0);
    check("rst_addr",  {sram_a_addr_o, sram_b_addr_o}, 0);
    check("rst_flags", {busy_o, done_o, mismatch_o}, 0);
    check("rst_stat",  {first_off_o, mismatch_cnt_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run(vecs[i], 0);

    // Stray start during RUN must not disturb the sweep.
    run(vecs[1], 5);

    // Abort at offset 5: back to IDLE next cycle, no done.
    begin
      int  issued = 0, guard = 0;
      bit  done_any = 1'b0;
      v = vecs[0];
      load(v);
      @(negedge clk);
      drive_start(v);
      while (issued < 6 && guard < 40) begin
        @(negedge clk);
        guard++;
        start_i = 1'b0;
        if (sram_a_ce_o) issued++;
      end
      check("abort_reach", issued, 6);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      check("abort_busy", busy_o, 0);
      check("abort_ce",   {sram_a_ce_o, sram_b_ce_o}, 0);
      for (int k = 0; k < 25; k++) begin
        @(negedge clk);
        if (done_o || sram_a_ce_o || busy_o) done_any = 1'b1;
      end
      check("abort_quiet", done_any, 0);
    end

    // start and abort together in IDLE: abort wins.
    @(negedge clk);
    drive_start(vecs[0]);
    abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    check("start_abort_busy", busy_o, 0);
    @(negedge clk);
    check("start_abort_ce", sram_a_ce_o, 0);

    // Asynchronous reset mid-sweep.
    v = '{base_a: 10'h000, base_b: 10'h100, len: 16, stop: 1'b0, mis0: 0, mis1: 1};
    load(v);
    @(negedge clk);
    drive_start(v);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    check("pre_rst_cnt",  mismatch_cnt_o, 2);
    check("pre_rst_busy", busy_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ce",    {sram_a_ce_o, sram_b_ce_o}, 0);
    check("arst_flags", {busy_o, done_o, mismatch_o}, 0);
    check("arst_stat",  {first_off_o, mismatch_cnt_o}, 0);
    check("arst_addr",  {sram_a_addr_o, sram_b_addr_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(vecs[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
